// File: rtl/dbg_apb_pkg.sv
// rtl/dbg_apb_pkg.sv - shared types and constants for the debug APB to BVCI bridge
//
// Purpose: FSM state encoding, BVCI command codes and default window/timeout values
// used by dbg_apb2bvci and its timeout sub-module.
package dbg_apb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0]  CMD_RD        = 2'b01;
  localparam logic [1:0]  CMD_WR        = 2'b10;
  localparam logic [23:0] WIN_BASE_DFLT = 24'hFFFF00;
  localparam logic [7:0]  CMD_TMO_DFLT  = 8'd64;

endpackage

// File: rtl/dbg_apb2bvci_tmo.sv
// rtl/dbg_apb2bvci_tmo.sv - command-phase timeout counter for the debug bridge
//
// Purpose: counts clk cycles spent waiting for dbg_cmdack and flags expiry.
// Ports:
//   clk, rst_a  clock and asynchronous active-high reset
//   clr         synchronous clear, wins over en
//   en          count one cycle
//   expired     counter has reached CMD_TMO-1 (holds there until cleared)
module dbg_apb2bvci_tmo #(
  parameter logic [7:0] CMD_TMO = 8'd64
) (
  input  logic clk,
  input  logic rst_a,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt_q;

  // Entered at 0, so the expiry edge is the CMD_TMO-th edge spent in the command phase.
  assign expired = (cnt_q == CMD_TMO - 8'd1);

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/dbg_apb2bvci.sv
// rtl/dbg_apb2bvci.sv - APB3 completer issuing single-beat BVCI debug transactions
//
// Purpose: turns one debug-APB transfer at a time into a BVCI command/response pair
// aimed at the debug register window selected by WIN_BASE.
// Ports:
//   clk, rst_a                    clock, asynchronous active-high reset
//   pclkdbg_en                    APB clock enable (qualifies all APB sampling/updates)
//   pseldbg/penabledbg/pwritedbg  APB control; paddrdbg word address, pwdatadbg write data
//   prdatadbg/preadydbg/pslverrdbg  APB completion (registered)
//   dbg_cmdval/dbg_cmdack         BVCI command handshake; dbg_address/be/cmd/wdata payload
//   dbg_rspval/dbg_rspack         BVCI response handshake; dbg_rdata/reop/rerr payload
module dbg_apb2bvci
  import dbg_apb_pkg::*;
#(
  parameter logic [23:0] WIN_BASE = WIN_BASE_DFLT,
  parameter logic [7:0]  CMD_TMO  = CMD_TMO_DFLT
) (
  input  logic        clk,
  input  logic        rst_a,
  input  logic        pclkdbg_en,
  input  logic        pseldbg,
  input  logic        penabledbg,
  input  logic        pwritedbg,
  input  logic [29:0] paddrdbg,
  input  logic [31:0] pwdatadbg,
  output logic [31:0] prdatadbg,
  output logic        preadydbg,
  output logic        pslverrdbg,
  output logic        dbg_cmdval,
  input  logic        dbg_cmdack,
  output logic [31:0] dbg_address,
  output logic [3:0]  dbg_be,
  output logic [1:0]  dbg_cmd,
  output logic [31:0] dbg_wdata,
  input  logic        dbg_rspval,
  output logic        dbg_rspack,
  input  logic [31:0] dbg_rdata,
  input  logic        dbg_reop,
  input  logic        dbg_rerr
);

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [1:0]  cmd_q, cmd_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        abort_q, abort_d;
  logic        cmdval_q, cmdval_d;
  logic        rspack_q, rspack_d;
  logic        pready_q, pready_d;
  logic [31:0] prdata_q, prdata_d;
  logic        pslverr_q, pslverr_d;
  logic        tmo_expired;
  logic        apb_setup;
  logic        host_gone;

  dbg_apb2bvci_tmo #(.CMD_TMO(CMD_TMO)) u_tmo (
    .clk     (clk),
    .rst_a   (rst_a),
    .clr     (state_q != CMD),
    .en      (state_q == CMD),
    .expired (tmo_expired)
  );

  assign apb_setup = pclkdbg_en & pseldbg & ~penabledbg;
  // Host abandoned the transfer, either earlier or on this enabled cycle.
  assign host_gone = abort_q | (pclkdbg_en & ~pseldbg);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    cmd_d     = cmd_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    abort_d   = abort_q;
    cmdval_d  = cmdval_q;
    rspack_d  = rspack_q;
    pready_d  = pready_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (apb_setup) begin
          addr_d  = paddrdbg;
          wdata_d = pwdatadbg;
          write_d = pwritedbg;
          rdata_d = '0;
          if (paddrdbg[29:6] == WIN_BASE) begin
            state_d  = CMD;
            cmdval_d = 1'b1;
            cmd_d    = pwritedbg ? CMD_WR : CMD_RD;
            err_d    = 1'b0;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
          end
        end
      end
      CMD: begin
        abort_d = host_gone;
        // An ack always wins; a response arriving alongside it is picked up in RSP.
        if (dbg_cmdack) begin
          cmdval_d = 1'b0;
          rspack_d = 1'b1;
          state_d  = RSP;
        end else if (tmo_expired) begin
          cmdval_d = 1'b0;
          err_d    = 1'b1;
          state_d  = host_gone ? IDLE : DONE;
        end
      end
      RSP: begin
        abort_d = host_gone;
        if (dbg_rspval) begin
          rspack_d = 1'b0;
          rdata_d  = write_q ? 32'd0 : dbg_rdata;
          err_d    = dbg_rerr | ~dbg_reop;
          state_d  = host_gone ? IDLE : DONE;
        end
      end
      DONE: begin
        // pready is held for exactly one enabled APB cycle, then everything clears.
        if (pclkdbg_en) begin
          if (pready_q) begin
            pready_d  = 1'b0;
            prdata_d  = '0;
            pslverr_d = 1'b0;
            state_d   = IDLE;
          end else if (pseldbg && penabledbg) begin
            pready_d  = 1'b1;
            prdata_d  = rdata_q;
            pslverr_d = err_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      cmd_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
      cmdval_q  <= 1'b0;
      rspack_q  <= 1'b0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      cmd_q     <= cmd_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      abort_q   <= abort_d;
      cmdval_q  <= cmdval_d;
      rspack_q  <= rspack_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign prdatadbg   = prdata_q;
  assign preadydbg   = pready_q;
  assign pslverrdbg  = pslverr_q;
  assign dbg_cmdval  = cmdval_q;
  assign dbg_address = {addr_q, 2'b00};
  assign dbg_be      = 4'hF;
  assign dbg_cmd     = cmd_q;
  assign dbg_wdata   = wdata_q;
  assign dbg_rspack  = rspack_q;

endmodule

// File: tb/tb_dbg_apb2bvci.sv
// tb/tb_dbg_apb2bvci.sv - self-checking bench for dbg_apb2bvci
module tb_dbg_apb2bvci;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pclkdbg_en = 1'b1;
  logic        pseldbg = 1'b0, penabledbg = 1'b0, pwritedbg = 1'b0;
  logic [29:0] paddrdbg = '0;
  logic [31:0] pwdatadbg = '0;
  logic [31:0] prdatadbg;
  logic        preadydbg, pslverrdbg;
  logic        dbg_cmdval;
  logic        dbg_cmdack = 1'b0;
  logic [31:0] dbg_address;
  logic [3:0]  dbg_be;
  logic [1:0]  dbg_cmd;
  logic [31:0] dbg_wdata;
  logic        dbg_rspval = 1'b0;
  logic        dbg_rspack;
  logic [31:0] dbg_rdata = '0;
  logic        dbg_reop = 1'b1;
  logic        dbg_rerr = 1'b0;

  dbg_apb2bvci dut (
    .clk(clk), .rst_a(rst), .pclkdbg_en(pclkdbg_en),
    .pseldbg(pseldbg), .penabledbg(penabledbg), .pwritedbg(pwritedbg),
    .paddrdbg(paddrdbg), .pwdatadbg(pwdatadbg),
    .prdatadbg(prdatadbg), .preadydbg(preadydbg), .pslverrdbg(pslverrdbg),
    .dbg_cmdval(dbg_cmdval), .dbg_cmdack(dbg_cmdack), .dbg_address(dbg_address),
    .dbg_be(dbg_be), .dbg_cmd(dbg_cmd), .dbg_wdata(dbg_wdata),
    .dbg_rspval(dbg_rspval), .dbg_rspack(dbg_rspack), .dbg_rdata(dbg_rdata),
    .dbg_reop(dbg_reop), .dbg_rerr(dbg_rerr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Stimulus knobs.
  logic       gated = 1'b0;
  logic [1:0] div = '0;
  logic       tgt_ack = 1'b1;
  logic       tgt_rsp = 1'b1;

  // Observations.
  int          cmdval_cnt = 0;
  int          pready_cnt = 0;
  logic [1:0]  cap_cmd;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        apb_glitch = 1'b0;
  logic        prev_en = 1'b1, have_prev = 1'b0, rst_seen = 1'b1;
  logic [33:0] prev_out;

  // APB clock enable: all ones, or one clk in four.
  always @(posedge clk) begin
    #1;
    div = div + 2'd1;
    pclkdbg_en = gated ? (div == 2'd0) : 1'b1;
  end

  // BVCI target: accept and respond one cycle after each request.
  always @(posedge clk) begin
    #1;
    dbg_cmdack = tgt_ack & dbg_cmdval;
    dbg_rspval = tgt_rsp & dbg_rspack;
  end

  always @(negedge clk) begin
    if (dbg_cmdval) begin
      cmdval_cnt = cmdval_cnt + 1;
      cap_cmd   = dbg_cmd;
      cap_addr  = dbg_address;
      cap_wdata = dbg_wdata;
      cap_be    = dbg_be;
    end
    if (preadydbg && pclkdbg_en) pready_cnt = pready_cnt + 1;
    // APB outputs must not move across an edge where the enable was low.
    if (have_prev && !prev_en && !rst && !rst_seen &&
        {preadydbg, pslverrdbg, prdatadbg} != prev_out)
      apb_glitch = 1'b1;
    prev_en   = pclkdbg_en;
    prev_out  = {preadydbg, pslverrdbg, prdatadbg};
    rst_seen  = rst;
    have_prev = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_en_negedge();
    @(negedge clk);
    while (!pclkdbg_en) @(negedge clk);
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int waits,
                          output logic done);
    int guard;
    done = 1'b0; waits = 0; rd = '0; err = 1'b0; guard = 0;
    wait_en_negedge();
    pseldbg = 1'b1; penabledbg = 1'b0; pwritedbg = wr;
    paddrdbg = addr[31:2]; pwdatadbg = wd;
    @(posedge clk);
    wait_en_negedge();
    penabledbg = 1'b1;
    while (!done && guard < 400) begin
      if (preadydbg) begin
        rd = prdatadbg; err = pslverrdbg; done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      if (!done) begin
        wait_en_negedge();
        guard++;
      end
    end
    @(negedge clk);
    pseldbg = 1'b0; penabledbg = 1'b0;
  endtask

  typedef struct {
    logic        gated;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        rerr;
    logic        reop;
    logic [31:0] exp_prdata;
    logic        exp_err;
    int          exp_cmdval;
    int          exp_waits;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] rd;
    logic        err, done;
    int          waits;

    vecs[0]  = '{0, 0, 32'hFFFF_0010, 32'h0,         1, 32'hA5A5_1234, 0, 1, 32'hA5A5_1234, 0, 1, 3};
    vecs[1]  = '{0, 1, 32'hFFFF_0004, 32'hDEAD_BEEF, 1, 32'hCAFE_0000, 0, 1, 32'h0,         0, 1, 3};
    vecs[2]  = '{0, 0, 32'h0000_1000, 32'h0,         1, 32'h1111_1111, 0, 1, 32'h0,         1, 0, 1};
    vecs[3]  = '{0, 0, 32'hFFFF_0020, 32'h0,         0, 32'h2222_2222, 0, 1, 32'h0,         1, 64, 65};
    vecs[4]  = '{0, 0, 32'hFFFF_0008, 32'h0,         1, 32'h1234_5678, 1, 1, 32'h1234_5678, 1, 1, 3};
    vecs[5]  = '{0, 0, 32'hFFFF_000C, 32'h0,         1, 32'h0BAD_F00D, 0, 0, 32'h0BAD_F00D, 1, 1, 3};
    vecs[6]  = '{0, 1, 32'hFFFE_FFFC, 32'h5555_AAAA, 1, 32'h0,         0, 1, 32'h0,         1, 0, 1};
    vecs[7]  = '{0, 0, 32'hFFFF_00FC, 32'h0,         1, 32'h89AB_CDEF, 0, 1, 32'h89AB_CDEF, 0, 1, 3};
    vecs[8]  = '{0, 1, 32'hFFFF_0100, 32'h0F0F_0F0F, 1, 32'h0,         0, 1, 32'h0,         1, 0, 1};
    vecs[9]  = '{1, 0, 32'hFFFF_0010, 32'h0,         1, 32'hA5A5_1234, 0, 1, 32'hA5A5_1234, 0, 1, 1};
    vecs[10] = '{1, 1, 32'hFFFF_0004, 32'hDEAD_BEEF, 1, 32'h0,         0, 1, 32'h0,         0, 1, 1};
    vecs[11] = '{1, 0, 32'hFFFF_0008, 32'h0,         1, 32'h1111_2222, 1, 1, 32'h1111_2222, 1, 1, 1};
    vecs[12] = '{1, 0, 32'h0000_1000, 32'h0,         1, 32'h0,         0, 1, 32'h0,         1, 0, 1};
    vecs[13] = '{1, 0, 32'hFFFF_0040, 32'h0,         0, 32'h0,         0, 1, 32'h0,         1, 64, 17};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_prdata",  prdatadbg, 32'h0);
    check("rst_pready",  {31'd0, preadydbg}, 32'h0);
    check("rst_pslverr", {31'd0, pslverrdbg}, 32'h0);
    check("rst_cmdval",  {31'd0, dbg_cmdval}, 32'h0);
    check("rst_rspack",  {31'd0, dbg_rspack}, 32'h0);
    check("rst_cmd",     {30'd0, dbg_cmd}, 32'h0);
    check("rst_be",      {28'd0, dbg_be}, 32'hF);

    for (int i = 0; i < 14; i++) begin
      gated = vecs[i].gated; tgt_ack = vecs[i].ack; tgt_rsp = 1'b1;
      dbg_rdata = vecs[i].rdata; dbg_rerr = vecs[i].rerr; dbg_reop = vecs[i].reop;
      repeat (5) @(negedge clk);
      cmdval_cnt = 0; pready_cnt = 0;
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, waits, done);
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
      check($sformatf("v%0d_prdata", i), rd, vecs[i].exp_prdata);
      check($sformatf("v%0d_pslverr", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_waits", i), waits, vecs[i].exp_waits);
      check($sformatf("v%0d_cmdval_clks", i), cmdval_cnt, vecs[i].exp_cmdval);
      check($sformatf("v%0d_pready_pulses", i), pready_cnt, 32'd1);
      if (vecs[i].exp_cmdval > 0) begin
        check($sformatf("v%0d_cmd", i), {30'd0, cap_cmd}, vecs[i].wr ? 32'd2 : 32'd1);
        check($sformatf("v%0d_addr", i), cap_addr, vecs[i].addr);
        check($sformatf("v%0d_be", i), {28'd0, cap_be}, 32'hF);
        if (vecs[i].wr) check($sformatf("v%0d_wdata", i), cap_wdata, vecs[i].wdata);
      end
    end

    // Host drops psel while the bridge waits for the response.
    gated = 1'b0; tgt_ack = 1'b1; tgt_rsp = 1'b0;
    dbg_rdata = 32'h7777_8888; dbg_rerr = 1'b0; dbg_reop = 1'b1;
    repeat (5) @(negedge clk);
    pready_cnt = 0;
    pseldbg = 1'b1; penabledbg = 1'b0; pwritedbg = 1'b0; paddrdbg = 30'h3FFF_C00C;
    @(negedge clk);
    penabledbg = 1'b1;
    @(negedge clk);
    check("abort_rspack_up", {31'd0, dbg_rspack}, 32'd1);
    pseldbg = 1'b0; penabledbg = 1'b0;
    repeat (3) @(negedge clk);
    tgt_rsp = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_rspack_down", {31'd0, dbg_rspack}, 32'd0);
    check("abort_no_pready", pready_cnt, 32'd0);
    dbg_rdata = 32'h4444_5555;
    apb_xfer(1'b0, 32'hFFFF_0014, 32'h0, rd, err, waits, done);
    check("after_abort_prdata", rd, 32'h4444_5555);
    check("after_abort_pslverr", {31'd0, err}, 32'd0);

    // Reset pulse while in RSP, then a normal read.
    tgt_rsp = 1'b0;
    repeat (3) @(negedge clk);
    pseldbg = 1'b1; penabledbg = 1'b0; pwritedbg = 1'b0; paddrdbg = 30'h3FFF_C004;
    @(negedge clk);
    penabledbg = 1'b1;
    @(negedge clk);
    check("rsp_rspack_up", {31'd0, dbg_rspack}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_rspack", {31'd0, dbg_rspack}, 32'd0);
    check("rstmid_cmdval", {31'd0, dbg_cmdval}, 32'd0);
    check("rstmid_pready", {31'd0, preadydbg}, 32'd0);
    check("rstmid_addr", dbg_address, 32'd0);
    @(negedge clk);
    rst = 1'b0; pseldbg = 1'b0; penabledbg = 1'b0; tgt_rsp = 1'b1;
    dbg_rdata = 32'hA5A5_1234;
    repeat (2) @(negedge clk);
    apb_xfer(1'b0, 32'hFFFF_0010, 32'h0, rd, err, waits, done);
    check("after_rst_done", {31'd0, done}, 32'd1);
    check("after_rst_prdata", rd, 32'hA5A5_1234);
    check("after_rst_pslverr", {31'd0, err}, 32'd0);
    check("after_rst_waits", waits, 32'd3);

    check("apb_outputs_only_on_enable", {31'd0, apb_glitch}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

endmodule
